wb_stage: RTL



---
 rtl/wb_stage.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Write-back stage: picks ALU / load / PC+4 / immediate, waits for variable-latency
// load data, extends and aligns it, and issues a one-cycle register-file write strobe.
module wb_stage #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_result_src,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_imm_ext,
  input  logic [2:0]      in_funct3,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_result,
  output logic            wb_err
);

  localparam int OFFW = $clog2(XLEN / 8);
  localparam int CW   = $clog2(TIMEOUT) + 1;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  logic [OFFW-1:0] ld_off;
  logic [2:0]      ld_f3;
  logic [4:0]      ld_rd;
  logic            ld_rw;

  logic            accept;
  logic [OFFW-1:0] in_off;
  logic            bad_load;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext;

  logic            valid_nxt, we_nxt, err_nxt;
  logic [4:0]      rd_nxt;
  logic [XLEN-1:0] result_nxt;

  function automatic logic illegal_f3(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b0;
      3'b011, 3'b110:                         return (XLEN != 64);
      default:                                return 1'b1;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [OFFW-1:0] off);
    case (f3)
      3'b001, 3'b101: return off[0];
      3'b010, 3'b110: return (off[1:0] != 2'b00);
      3'b011:         return (off != '0);
      default:        return 1'b0;
    endcase
  endfunction

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign in_off   = in_alu_result[OFFW-1:0];
  assign bad_load = illegal_f3(in_funct3) || misaligned(in_funct3, in_off);

  // Memory returns the whole aligned word; bring the addressed field down to bit 0.
  assign shifted  = mem_rdata >> {ld_off, 3'b000};

  always_comb begin
    ext = shifted;
    case (ld_f3)
      3'b000:  ext = XLEN'($signed(shifted[7:0]));
      3'b001:  ext = XLEN'($signed(shifted[15:0]));
      3'b010:  ext = XLEN'($signed(shifted[31:0]));
      3'b100:  ext = XLEN'(shifted[7:0]);
      3'b101:  ext = XLEN'(shifted[15:0]);
      3'b110:  ext = XLEN'(shifted[31:0]);
      default: ext = shifted;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    valid_nxt  = 1'b0;
    we_nxt     = 1'b0;
    err_nxt    = 1'b0;
    rd_nxt     = wb_rd;
    result_nxt = wb_result;
    case (state)
      S_IDLE: begin
        if (accept) begin
          rd_nxt = in_rd;
          if (in_result_src != 2'b01) begin
            valid_nxt = 1'b1;
            we_nxt    = in_reg_write && (in_rd != 5'd0);
            case (in_result_src)
              2'b00:   result_nxt = in_alu_result;
              2'b10:   result_nxt = in_pc_plus4;
              default: result_nxt = in_imm_ext;
            endcase
          end else if (bad_load) begin
            valid_nxt  = 1'b1;
            err_nxt    = 1'b1;
            result_nxt = '0;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = '0;
          end
        end
      end
      S_WAIT: begin
        // A response in the timeout cycle still completes the load normally.
        if (mem_rvalid) begin
          valid_nxt  = 1'b1;
          we_nxt     = ld_rw && (ld_rd != 5'd0);
          rd_nxt     = ld_rd;
          result_nxt = ext;
          state_nxt  = S_IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          valid_nxt  = 1'b1;
          err_nxt    = 1'b1;
          rd_nxt     = ld_rd;
          result_nxt = '0;
          state_nxt  = S_IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_off <= '0;
      ld_f3  <= '0;
      ld_rd  <= '0;
      ld_rw  <= 1'b0;
    end else if (accept) begin
      ld_off <= in_off;
      ld_f3  <= in_funct3;
      ld_rd  <= in_rd;
      ld_rw  <= in_reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_err    <= 1'b0;
      wb_rd     <= '0;
      wb_result <= '0;
    end else begin
      wb_valid  <= valid_nxt;
      wb_we     <= we_nxt;
      wb_err    <= err_nxt;
      wb_rd     <= rd_nxt;
      wb_result <= result_nxt;
    end
  end

endmodule
